usiq_byte_packer: RTL
=====================

Name: usiq_byte_packer

Overview:
Upstream IQ framer. It reads 24-bit IQ words from the upstream IQ FIFO read side: show-ahead, AXI-stream, with tlast and a fill-level count. It emits a byte stream of fixed 512-byte HPSDR-style frames toward the Ethernet transmit path. Each frame is an 8-byte header (sync plus C&C), then 63 samples of 8 bytes each (I24, Q24, mic16). A frame starts only when the FIFO holds a complete frame's worth of words, so the packer never underflows mid-frame in normal operation.

Parameters:
SAMPLES, 63, IQ sample pairs per frame (payload = SAMPLES*8 bytes)
START_WORDS, 126, minimum in_tlength required to start a frame (2*SAMPLES)
SYNC_BYTE, 8'h7F, value of header bytes 0..2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_tdata  in  24  IQ word from FIFO (show-ahead); I then Q
in_tvalid  in  1  FIFO not empty
in_tready  out  1  pop strobe to FIFO
in_tlast  in  1  marks Q word (second word of a sample pair)
in_tlength  in  11  FIFO fill level in words
cc_data  in  40  five C&C bytes; byte 3 = cc_data[39:32] ... byte 7 = cc_data[7:0]
cc_ack  out  1  one-cycle pulse when cc_data is latched
out_tdata  out  8  frame byte
out_tvalid  out  1  out_tdata valid
out_tready  in  1  downstream accept
out_tlast  out  1  high on byte 511
out_tuser  out  1  high on byte 0 (start of frame)
resync_count  out  8  saturating count of alignment errors

Behaviour:
- Decided: single clock clk; rst is synchronous, active-high. On rst the block goes to IDLE and clears all counters and resync_count. out_tvalid, in_tready, cc_ack, out_tlast and out_tuser are 0 in the cycle after rst is sampled.
- Reset mid-frame abandons the partial frame immediately. No further bytes or pops occur. The next frame starts fresh with the sync bytes.
- States are IDLE, HDR, IQ, MIC.
- Counters:
  - hdr_idx 0..7
  - word_sel: 0 = I, 1 = Q
  - byte_idx 0..2
  - mic_idx 0..1
  - sample_cnt 0..SAMPLES-1
- IDLE -> HDR when in_tlength >= START_WORDS. In that same cycle cc_data is latched and cc_ack pulses. out_tvalid rises the next cycle. Otherwise the block stays in IDLE with out_tvalid=0.
- HDR: out_tdata = SYNC_BYTE for hdr_idx 0..2, then latched C&C bytes for 3..7. out_tuser=1 at hdr_idx 0.
  - hdr_idx advances only on out_tvalid & out_tready.
  - After hdr_idx 7 is accepted, go to IQ with word_sel=0, byte_idx=0, sample_cnt=0.
- IQ: out_tvalid = in_tvalid. out_tdata = in_tdata byte, MSB first: [23:16], [15:8], [7:0].
  - byte_idx advances on handshake.
  - in_tready=1 in exactly the cycle the byte_idx=2 byte is accepted, i.e. the word is popped on its last byte.
  - After the I word, word_sel=1. After the Q word, go to MIC.
- MIC: out_tdata=8'h00, out_tvalid=1, two bytes. Then sample_cnt increments and the block returns to IQ (word_sel=0). If sample_cnt = SAMPLES-1, it returns to IDLE instead.
- out_tlast=1 only on the second MIC byte of the last sample (frame byte 511). Each frame is exactly 512 bytes and 126 pops.
- Alignment rules:
  - At word_sel=0, byte_idx=0 with in_tvalid & in_tlast: the word is discarded. in_tready=1, out_tvalid=0 that cycle, resync_count increments (saturates at 255), and the state is unchanged.
  - A Q word with in_tlast=0 is still emitted and resync_count increments.
- Output data and valid are combinational from state and in_tdata. While out_tvalid & ~out_tready, out_tdata and out_tuser/out_tlast hold stable, and in_tready stays 0.
- in_tvalid low during IQ stalls output (out_tvalid=0) without a state change. MIC and HDR never depend on in_tvalid.
- in_tlength is sampled only in IDLE. A back-to-back frame may start in the cycle after the last byte.

Decomposition:
- Package usiq_pkg holds:
  - the state enum (IDLE, HDR, IQ, MIC)
  - HDR_BYTES=8
  - BYTES_PER_SAMPLE=8
  - FRAME_BYTES=512
  - sync constant
- No sub-module. Single FSM with counters, roughly 200 lines.

Test Plan:
1. in_tlength=125 for 50 cycles -> out_tvalid stays 0. Set 126 -> cc_ack pulses, next cycle out_tvalid=1, bytes 7F 7F 7F then cc_data bytes in order, out_tuser on the first byte.
2. FIFO preloaded with 63 pairs I=24'h123456 (tlast=0), Q=24'hABCDEF (tlast=1), out_tready=1 -> payload repeats 12 34 56 AB CD EF 00 00. Exactly 512 bytes, out_tlast on byte 511, 126 pops, return to IDLE.
3. Same traffic with random out_tready (50%) -> byte sequence identical to scenario 2, data held stable while stalled, no pops during stalls.
4. First IQ word carries tlast=1 (stray Q), followed by 126 aligned words -> stray word popped silently, resync_count=1, frame contents identical to scenario 2.
5. in_tvalid deasserted for 10 cycles after byte 1 of a Q word -> out_tvalid=0 for those cycles, then resumes with byte 2 of the same word, no lost or duplicated bytes.
6. rst asserted while byte 200 is presented -> next cycle out_tvalid=0, in_tready=0, resync_count=0. With in_tlength>=126, the next frame begins with 7F.

Source files
------------

// File: rtl/usiq_pkg.sv
// Shared types and constants for the upstream IQ byte packer: FSM states and
// the fixed HPSDR-style frame geometry.
package usiq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    IQ,
    MIC
  } state_t;

  localparam int HDR_BYTES        = 8;
  localparam int BYTES_PER_SAMPLE = 8;
  localparam int FRAME_BYTES      = 512;
  localparam logic [7:0] SYNC     = 8'h7F;

endpackage

// File: rtl/usiq_byte_packer.sv
// Upstream IQ framer: turns 24-bit I/Q words from a show-ahead FIFO into
// 512-byte frames (sync + C&C header, then I24/Q24/mic16 per sample).
module usiq_byte_packer
  import usiq_pkg::*;
#(
  parameter int         SAMPLES     = 63,
  parameter int         START_WORDS = 126,
  parameter logic [7:0] SYNC_BYTE   = SYNC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic        in_tlast,
  input  logic [10:0] in_tlength,
  input  logic [39:0] cc_data,
  output logic        cc_ack,
  output logic [7:0]  out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast,
  output logic        out_tuser,
  output logic [7:0]  resync_count
);

  localparam logic [5:0]  LAST_SAMPLE = 6'(SAMPLES - 1);
  localparam logic [10:0] START_LEN   = 11'(START_WORDS);

  state_t      state_q, state_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic        word_sel_q, word_sel_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        mic_idx_q, mic_idx_d;
  logic [5:0]  sample_cnt_q, sample_cnt_d;
  logic [39:0] cc_q, cc_d;
  logic [7:0]  resync_q, resync_d;
  logic        armed_q, armed_d;

  logic start;
  logic stray;
  logic q_misaligned;
  logic hs;

  // armed_q keeps the cycle right after reset quiet even if the FIFO is full.
  assign start = (state_q == IDLE) && armed_q && (in_tlength >= START_LEN);
  assign stray = (state_q == IQ) && !word_sel_q && (byte_idx_q == 2'd0) &&
                 in_tvalid && in_tlast;
  assign hs    = out_tvalid && out_tready;
  assign q_misaligned = (state_q == IQ) && word_sel_q && in_tready && !in_tlast;

  assign resync_count = resync_q;

  always_comb begin
    out_tvalid = 1'b0;
    out_tdata  = 8'h00;
    out_tuser  = 1'b0;
    out_tlast  = 1'b0;
    in_tready  = 1'b0;
    cc_ack     = 1'b0;
    unique case (state_q)
      IDLE: cc_ack = start;
      HDR: begin
        out_tvalid = 1'b1;
        out_tuser  = (hdr_idx_q == 3'd0);
        case (hdr_idx_q)
          3'd3:    out_tdata = cc_q[39:32];
          3'd4:    out_tdata = cc_q[31:24];
          3'd5:    out_tdata = cc_q[23:16];
          3'd6:    out_tdata = cc_q[15:8];
          3'd7:    out_tdata = cc_q[7:0];
          default: out_tdata = SYNC_BYTE;
        endcase
      end
      IQ: begin
        out_tvalid = in_tvalid && !stray;
        case (byte_idx_q)
          2'd0:    out_tdata = in_tdata[23:16];
          2'd1:    out_tdata = in_tdata[15:8];
          default: out_tdata = in_tdata[7:0];
        endcase
        in_tready = stray || (in_tvalid && out_tready && (byte_idx_q == 2'd2));
      end
      MIC: begin
        out_tvalid = 1'b1;
        out_tlast  = mic_idx_q && (sample_cnt_q == LAST_SAMPLE);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    word_sel_d   = word_sel_q;
    byte_idx_d   = byte_idx_q;
    mic_idx_d    = mic_idx_q;
    sample_cnt_d = sample_cnt_q;
    cc_d         = cc_q;
    resync_d     = resync_q;
    armed_d      = 1'b1;

    if ((stray || q_misaligned) && (resync_q != 8'hFF)) begin
      resync_d = resync_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = HDR;
          hdr_idx_d = 3'd0;
          cc_d      = cc_data;
        end
      end
      HDR: begin
        if (hs) begin
          if (hdr_idx_q == 3'd7) begin
            state_d      = IQ;
            word_sel_d   = 1'b0;
            byte_idx_d   = 2'd0;
            sample_cnt_d = 6'd0;
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end
      end
      IQ: begin
        if (hs) begin
          if (byte_idx_q == 2'd2) begin
            byte_idx_d = 2'd0;
            if (word_sel_q) begin
              word_sel_d = 1'b0;
              mic_idx_d  = 1'b0;
              state_d    = MIC;
            end else begin
              word_sel_d = 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      MIC: begin
        if (hs) begin
          if (mic_idx_q) begin
            mic_idx_d = 1'b0;
            if (sample_cnt_q == LAST_SAMPLE) begin
              state_d = IDLE;
            end else begin
              sample_cnt_d = sample_cnt_q + 6'd1;
              state_d      = IQ;
            end
          end else begin
            mic_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hdr_idx_q    <= 3'd0;
      word_sel_q   <= 1'b0;
      byte_idx_q   <= 2'd0;
      mic_idx_q    <= 1'b0;
      sample_cnt_q <= 6'd0;
      cc_q         <= 40'd0;
      resync_q     <= 8'd0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      word_sel_q   <= word_sel_d;
      byte_idx_q   <= byte_idx_d;
      mic_idx_q    <= mic_idx_d;
      sample_cnt_q <= sample_cnt_d;
      cc_q         <= cc_d;
      resync_q     <= resync_d;
      armed_q      <= armed_d;
    end
  end

endmodule
